// File: rtl/des_expand_mix.sv
// DES round front end: E-expansion of the right half XORed with the subkey, buffered in a 2-entry FIFO.
// Optional macro XFER_COUNT_EN adds a 16-bit count of emitted words on port xfer_count.
module des_expand_mix #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      r_half,
    input  logic [47:0]      subkey,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      sbox_in,
    output logic [TAG_W-1:0] tag_out
`ifdef XFER_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    // Each 6-bit S-box group k takes DES bits 4k..4k+5 of the right half,
    // with bit 0 wrapping to bit 32 and bit 33 wrapping to bit 1.
    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        int          b;
        e = '0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 6; j++) begin
                b = 4 * k + j;
                if (b == 0)  b = 32;
                if (b == 33) b = 1;
                e[47 - (6 * k + j)] = r[32 - b];
            end
        end
        return e;
    endfunction

    logic [47:0]      data_mem [2];
    logic [TAG_W-1:0] tag_mem  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             emit;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // Gating the head with out_valid gives zero outputs when empty without resetting storage.
    assign sbox_in   = out_valid ? data_mem[rd_ptr] : '0;
    assign tag_out   = out_valid ? tag_mem[rd_ptr]  : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (emit)   rd_ptr <= ~rd_ptr;
            case ({accept, emit})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr] <= expand(r_half) ^ subkey;
            tag_mem[wr_ptr]  <= tag_in;
        end
    end

`ifdef XFER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)       xfer_count <= 16'h0000;
        else if (emit) xfer_count <= xfer_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_des_expand_mix.sv
// Self-checking bench for des_expand_mix: directed vectors plus random traffic against
// a table-driven E-expansion model and a queue-based FIFO model.
module tb_des_expand_mix;
    localparam int TAG_W = 4;

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    typedef struct {
        logic [47:0]      data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      r_half;
    logic [47:0]      subkey;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [47:0]      sbox_in;
    logic [TAG_W-1:0] tag_out;
`ifdef XFER_COUNT_EN
    logic [15:0]      xfer_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    entry_t           model_q [$];
    logic [TAG_W-1:0] emitted [$];

    des_expand_mix #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_half    (r_half),
        .subkey    (subkey),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sbox_in   (sbox_in),
        .tag_out   (tag_out)
`ifdef XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    // DES numbering: bit n of the 32-bit half is r[32-n]; output position p lands on bit 48-p.
    function automatic logic [47:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        for (int p = 1; p <= 48; p++) e[48 - p] = r[32 - E_TAB[p - 1]];
        return e ^ k;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: update the model with what the DUT sees at the edge, then compare at the falling edge.
    task automatic step();
        bit     can_accept;
        entry_t e;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            can_accept = (model_q.size() < 2);
            if (out_ready && model_q.size() > 0) begin
                emitted.push_back(model_q[0].tag);
                void'(model_q.pop_front());
            end
            if (in_valid && can_accept) begin
                e.data = ref_f(r_half, subkey);
                e.tag  = tag_in;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        check("sbox_in", 64'(sbox_in), model_q.size() > 0 ? 64'(model_q[0].data) : 64'h0);
        check("tag_out", 64'(tag_out), model_q.size() > 0 ? 64'(model_q[0].tag) : 64'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        r_half = '0; subkey = '0; tag_in = '0;

        // Reset state
        step();
        rst = 1'b0;
        step();
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_sbox_in", 64'(sbox_in), 64'h0);

        // Zero right half: output is the subkey, one cycle after acceptance
        in_valid = 1'b1; out_ready = 1'b1; r_half = 32'h0; subkey = 48'h123456789ABC; tag_in = 4'h5;
        step();
        check("vec0_valid", 64'(out_valid), 64'h1);
        check("vec0_sbox", 64'(sbox_in), 64'h123456789ABC);

        // Edge bits of the right half reach both ends of the expansion
        subkey = '0;
        r_half = 32'h80000000; step();
        check("vec_msb", 64'(sbox_in), 64'h400000000001);
        r_half = 32'h00000001; step();
        check("vec_lsb", 64'(sbox_in), 64'h800000000002);
        r_half = 32'hFFFFFFFF; step();
        check("vec_ones", 64'(sbox_in), 64'hFFFFFFFFFFFF);
        in_valid = 1'b0; step(); step();

        // Back-pressure: fill two, hold the third, then drain in order
        emitted.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        tag_in = 4'd1; r_half = $urandom; subkey = {$urandom, $urandom} & 48'hFFFFFFFFFFFF; step();
        tag_in = 4'd2; r_half = $urandom; step();
        tag_in = 4'd3; r_half = $urandom; step();
        check("full_in_ready", 64'(in_ready), 64'h0);
        step();
        out_ready = 1'b1; step(); step();
        in_valid = 1'b0; step(); step();
        check("order_count", 64'(emitted.size()), 64'd3);
        for (int i = 0; i < 3 && i < emitted.size(); i++)
            check("order_tag", 64'(emitted[i]), 64'(i + 1));

        // Streaming: one word per cycle with in_ready never dropping
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r_half = $urandom;
            subkey = {16'($urandom), $urandom};
            tag_in = 4'($urandom);
            step();
            check("stream_in_ready", 64'(in_ready), 64'h1);
        end

        // Random valid/ready mix
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            r_half    = $urandom;
            subkey    = {16'($urandom), $urandom};
            tag_in    = 4'($urandom);
            step();
        end

        // Reset with two buffered words and a word offered in the reset cycle
        out_ready = 1'b0; in_valid = 1'b1;
        step(); step(); step();
        rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("post_rst_out_valid", 64'(out_valid), 64'h0);
        check("post_rst_in_ready", 64'(in_ready), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale", 64'(out_valid), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
